mux_scan_reg: RTL
=================

// Module: mux_scan_reg
// PURPOSE
//  Parametrised, registered N-to-1 multiplexer; successor to the fixed 8x1 combinational mux.
//  Selects one WIDTH-bit channel from a packed bus, either by an explicit select or by an
//  internal round-robin scan counter. Result is registered behind a valid/ready handshake.
//  Sits between channel sources (switches, counters) and display/output stages.
// PARAMETERS
//  CHANNELS  8  number of input channels, >=2
//  WIDTH     1  bits per channel, >=1
//  SW        $clog2(CHANNELS)  select width (localparam, not overridable)
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  w          in   CHANNELS*WIDTH  packed channels; channel k = w[k*WIDTH +: WIDTH]
//  s          in   SW              manual select
//  scan_en    in   1               1 = select from scan counter, 0 = use s
//  scan_clr   in   1               synchronous clear of scan counter to 0
//  in_valid   in   1               request a sample this cycle
//  in_ready   out  1               = !out_valid | out_ready (combinational)
//  y          out  WIDTH           registered selected channel
//  y_ch       out  SW              channel index that produced y
//  y_err      out  1               selected index was >= CHANNELS
//  out_valid  out  1               y/y_ch/y_err hold a sample
//  out_ready  in   1               consumer accepts sample
// BEHAVIOUR
//  - Reset: y=0, y_ch=0, y_err=0, out_valid=0, scan counter=0. rst overrides all other inputs.
//  - sel = scan_en ? cnt : s. Transfer (in_valid & in_ready): y<=channel[sel], y_ch<=sel,
//    y_err<=(sel>=CHANNELS), out_valid<=1. Latency 1 clk from transfer to out_valid.
//  - sel >= CHANNELS (non-power-of-2 CHANNELS): y<=0, y_err<=1; never index out of range.
//  - No transfer & out_ready: out_valid<=0; y/y_ch/y_err hold stale values.
//  - out_valid & !out_ready: all outputs hold; in_ready=0 (backpressure), w/s ignored.
//  - out_valid & out_ready & in_valid same cycle: new sample replaces old, out_valid stays 1
//    (full throughput, one sample per clock).
//  - Scan counter: increments only on a transfer with scan_en=1; wraps CHANNELS-1 -> 0.
//    Holds when scan_en=0. scan_clr has priority over increment; a transfer in the
//    scan_clr cycle samples with the pre-clear cnt, next cnt=0.
//  - Toggling scan_en does not reset the counter; it resumes where it stopped.
// CONFIGURATION
//  - MUX_SCAN_PARITY_EN defined: extra output y_par (1 bit) = ^y, registered with y,
//    reset 0, held under backpressure like y.
//  - Undefined: port y_par absent; no parity logic.
// STRUCTURE
//  - Package mux_pkg: function clog2_min1 (returns >=1), default CHANNELS/WIDTH constants.
//  - Sub-module mux_scan_counter (CHANNELS): clk, rst, clr, inc -> cnt[SW-1:0], wrap logic.
//  - Top: select logic, output register, handshake; no other hierarchy.
// TESTING
//  1 Defaults, w=8'b11101010, s=3'd5, scan_en=0, in_valid=1, out_ready=1 -> next clk y=1, y_ch=5, out_valid=1.
//  2 Same w, scan_en=1, 8 transfers -> y sequence 0,1,0,1,0,1,1,1 on y_ch 0..7, then y_ch wraps to 0.
//  3 out_ready=0 with out_valid=1, change w and s -> in_ready=0, y/y_ch unchanged for 4 clks; release -> new sample next clk.
//  4 CHANNELS=5, s=3'd6 -> y=0, y_err=1; s=3'd4 -> y=channel 4, y_err=0.
//  5 rst asserted mid-scan (cnt=3, out_valid=1) -> next clk all outputs 0, cnt=0; scan_clr with transfer -> sample cnt, then cnt=0.
//  6 MUX_SCAN_PARITY_EN, WIDTH=4, channel=4'b1011 -> y_par=1; undefined build compiles without y_par.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered scan multiplexer.
package mux_pkg;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_WIDTH    = 1;

    // Ceiling log2 that never returns less than 1, so a select bus always has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_counter.sv
// Round-robin channel counter: clears on clr, advances on inc, wraps CHANNELS-1 -> 0.
module mux_scan_counter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int SW       = clog2_min1(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [SW-1:0] cnt
);

    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

    logic [SW-1:0] cnt_d;
    logic [SW-1:0] cnt_q;

    // Next count: clear wins over increment; wrap at the last channel.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + SW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N-to-1 multiplexer with manual or round-robin select and a
// valid/ready output handshake.
// Optional build macro MUX_SCAN_PARITY_EN adds output y_par = ^y.
module mux_scan_reg
    import mux_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int WIDTH    = DEF_WIDTH,
    localparam int SW       = clog2_min1(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] w,
    input  logic [SW-1:0]             s,
    input  logic                      scan_en,
    input  logic                      scan_clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          y,
    output logic [SW-1:0]             y_ch,
    output logic                      y_err,
    output logic                      out_valid,
`ifdef MUX_SCAN_PARITY_EN
    output logic                      y_par,
`endif
    input  logic                      out_ready
);

    // Select values at or above this bound do not name a real channel.
    localparam logic [SW:0] CHAN_LIM = (SW + 1)'(CHANNELS);

    logic [SW-1:0]    cnt_s;
    logic [SW-1:0]    sel_s;
    logic             xfer_s;
    logic             err_s;
    logic [WIDTH-1:0] chan_s;

    logic [WIDTH-1:0] y_d,  y_q;
    logic [SW-1:0]    ch_d, ch_q;
    logic             err_d, err_q;
    logic             ov_d, ov_q;
`ifdef MUX_SCAN_PARITY_EN
    logic             par_d, par_q;
`endif

    mux_scan_counter #(.CHANNELS(CHANNELS)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (scan_clr),
        .inc (xfer_s & scan_en),
        .cnt (cnt_s)
    );

    assign in_ready = ~ov_q | out_ready;
    assign xfer_s   = in_valid & in_ready;
    assign sel_s    = scan_en ? cnt_s : s;
    assign err_s    = ({1'b0, sel_s} >= CHAN_LIM);

    // Channel pick by OR of masked lanes: an out-of-range select matches no lane and yields 0.
    always_comb begin
        chan_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            chan_s = chan_s | ({WIDTH{sel_s == SW'(k)}} & w[k*WIDTH +: WIDTH]);
        end
    end

    // Output register next state: load on transfer, otherwise hold; valid drops once consumed.
    always_comb begin
        y_d   = y_q;
        ch_d  = ch_q;
        err_d = err_q;
`ifdef MUX_SCAN_PARITY_EN
        par_d = par_q;
`endif
        if (xfer_s) begin
            y_d   = chan_s;
            ch_d  = sel_s;
            err_d = err_s;
`ifdef MUX_SCAN_PARITY_EN
            par_d = ^chan_s;
`endif
        end else begin
            y_d   = y_q;
            ch_d  = ch_q;
            err_d = err_q;
        end
        ov_d = xfer_s | (ov_q & ~out_ready);
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            ch_q  <= '0;
            err_q <= 1'b0;
            ov_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            y_q   <= y_d;
            ch_q  <= ch_d;
            err_q <= err_d;
            ov_q  <= ov_d;
`ifdef MUX_SCAN_PARITY_EN
            par_q <= par_d;
`endif
        end
    end

    assign y         = y_q;
    assign y_ch      = ch_q;
    assign y_err     = err_q;
    assign out_valid = ov_q;
`ifdef MUX_SCAN_PARITY_EN
    assign y_par     = par_q;
`endif

endmodule
